reglist_transfer_seq: RTL and testbench

- Multi-register transfer sequencer for Thumb PUSH, POP, LDMIA and STMIA.
- Sits between the instruction decoder and the core register file.
- Walks the register list one word at a time and drives the register file's read/write ports and a single-word data-bus handshake.
- Writes back the final base or SP value at the end.

---
 rtl/cm0_seq_pkg.sv | 30 +++
 rtl/reglist_picker.sv | 26 ++
 rtl/reglist_transfer_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_reglist_transfer_seq.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cm0_seq_pkg.sv
// Shared encodings for the Thumb multi-register transfer sequencer.
package cm0_seq_pkg;

  typedef enum logic [1:0] {
    OP_STMIA = 2'b00,
    OP_LDMIA = 2'b01,
    OP_PUSH  = 2'b10,
    OP_POP   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_XFER,
    S_WB,
    S_DONE,
    S_FAULT
  } state_e;

  localparam logic [3:0] REG_SP = 4'hd;
  localparam logic [3:0] REG_LR = 4'he;
  localparam logic [3:0] REG_PC = 4'hf;

  localparam int WORD_BYTES = 4;

  function automatic logic op_is_store(input op_e op);
    return (op == OP_STMIA) || (op == OP_PUSH);
  endfunction

endpackage

// File: rtl/reglist_picker.sv
// Combinational register-list helper: lowest set bit, empty flag and popcount.
module reglist_picker #(
  parameter int LIST_W = 8,
  parameter int IDX_W  = $clog2(LIST_W),
  parameter int CNT_W  = $clog2(LIST_W + 1)
) (
  input  logic [LIST_W-1:0] list,
  output logic [IDX_W-1:0]  low_idx,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  // Scan from the top so the last hit is the lowest index.
  always_comb begin
    low_idx = '0;
    count   = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list[i]) begin
        low_idx = IDX_W'(i);
      end
      count = count + CNT_W'(list[i]);
    end
    empty = ~|list;
  end

endmodule

// File: rtl/reglist_transfer_seq.sv
// Thumb PUSH/POP/LDMIA/STMIA sequencer: walks the register list one word per bus transfer.
// Optional misaligned-base detection is built when SEQ_ALIGN_CHECK_EN is defined.
module reglist_transfer_seq
  import cm0_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LIST_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [LIST_W-1:0] reg_list,
  input  logic              extra,
  input  logic [2:0]        base_idx,
  input  logic [ADDR_W-1:0] base_val,
  output logic              busy,
  output logic              done,
  output logic [3:0]        rf_raddr,
  input  logic [ADDR_W-1:0] rf_rdata,
  output logic [3:0]        rf_waddr,
  output logic [ADDR_W-1:0] rf_wdata,
  output logic              rf_ld_rd,
  output logic              rf_ld_pc,
  output logic              rf_ld_sp,
  output logic [ADDR_W-1:0] rf_sp_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              fault
);

  localparam int IDX_W = $clog2(LIST_W);
  localparam int CNT_W = $clog2(LIST_W + 1);

  state_e            state, state_nx;
  op_e               op_r;
  logic [LIST_W-1:0] remaining;
  logic              extra_r;
  logic [3:0]        base_idx_r;
  logic [ADDR_W-1:0] addr_r, wb_val_r, wdata_r, ld_data_r;
  logic [3:0]        cur_reg_r, ld_reg_r;
  logic              ld_pending_r, wb_suppress_r, empty_op_r;

  logic [LIST_W-1:0] pick_list;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_empty;
  logic [CNT_W-1:0]  pick_cnt;
  logic [CNT_W:0]    n_start;
  logic [ADDR_W-1:0] base_al, span;
  logic [3:0]        sel_reg;
  logic              is_store, misaligned;

  // The picker counts the incoming list while idle and walks the remaining list afterwards.
  assign pick_list = (state == S_IDLE) ? reg_list : remaining;

  reglist_picker #(
    .LIST_W(LIST_W),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_picker (
    .list   (pick_list),
    .low_idx(pick_idx),
    .empty  (pick_empty),
    .count  (pick_cnt)
  );

  assign n_start  = {1'b0, pick_cnt} + (CNT_W + 1)'(extra & op[1]);
  assign base_al  = base_val & ~ADDR_W'(3);
  assign span     = ADDR_W'(n_start) * ADDR_W'(WORD_BYTES);
  assign is_store = op_is_store(op_r);
  assign sel_reg  = pick_empty ? ((op_r == OP_PUSH) ? REG_LR : REG_PC) : 4'(pick_idx);

`ifdef SEQ_ALIGN_CHECK_EN
  assign misaligned = |base_val[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      op_r          <= OP_STMIA;
      remaining     <= '0;
      extra_r       <= 1'b0;
      base_idx_r    <= '0;
      addr_r        <= '0;
      wb_val_r      <= '0;
      wdata_r       <= '0;
      ld_data_r     <= '0;
      cur_reg_r     <= '0;
      ld_reg_r      <= '0;
      ld_pending_r  <= 1'b0;
      wb_suppress_r <= 1'b0;
      empty_op_r    <= 1'b0;
    end else begin
      state        <= state_nx;
      ld_pending_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r          <= op_e'(op);
            remaining     <= reg_list;
            extra_r       <= extra & op[1];
            base_idx_r    <= {1'b0, base_idx};
            addr_r        <= (op_e'(op) == OP_PUSH) ? base_al - span : base_al;
            wb_val_r      <= (op_e'(op) == OP_PUSH) ? base_al - span : base_al + span;
            wb_suppress_r <= (op_e'(op) == OP_LDMIA) && reg_list[base_idx];
            empty_op_r    <= (n_start == '0);
          end
        end
        S_PREP: begin
          cur_reg_r <= sel_reg;
          wdata_r   <= rf_rdata;
          if (!pick_empty) begin
            remaining[pick_idx] <= 1'b0;
          end else begin
            extra_r <= 1'b0;
          end
        end
        S_XFER: begin
          if (mem_ack) begin
            addr_r <= addr_r + ADDR_W'(WORD_BYTES);
            if (!is_store) begin
              ld_data_r    <= mem_rdata;
              ld_reg_r     <= cur_reg_r;
              ld_pending_r <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // A load result from the previous cycle is written back whatever state we are in now.
  always_comb begin
    state_nx    = state;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    fault       = 1'b0;
    rf_raddr    = '0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    rf_ld_rd    = 1'b0;
    rf_ld_pc    = 1'b0;
    rf_ld_sp    = 1'b0;
    rf_sp_wdata = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    if (ld_pending_r) begin
      if (ld_reg_r == REG_PC) begin
        rf_ld_pc = 1'b1;
        rf_waddr = REG_PC;
        rf_wdata = ld_data_r & ~ADDR_W'(1);
      end else begin
        rf_ld_rd = 1'b1;
        rf_waddr = ld_reg_r;
        rf_wdata = ld_data_r;
      end
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          if (misaligned) begin
            state_nx = S_FAULT;
          end else if (n_start == '0) begin
            state_nx = S_WB;
          end else begin
            state_nx = S_PREP;
          end
        end
      end
      S_PREP: begin
        rf_raddr = sel_reg;
        state_nx = S_XFER;
      end
      S_XFER: begin
        mem_req   = 1'b1;
        mem_we    = is_store;
        mem_addr  = addr_r;
        mem_wdata = is_store ? wdata_r : '0;
        if (mem_ack) begin
          state_nx = (|remaining || extra_r) ? S_PREP : S_WB;
        end
      end
      S_WB: begin
        // Rn writeback shares the Rd port with load results, so it waits out a pending strobe.
        if (empty_op_r || (op_r == OP_LDMIA && wb_suppress_r)) begin
          state_nx = S_DONE;
        end else if (op_r == OP_PUSH || op_r == OP_POP) begin
          rf_ld_sp    = 1'b1;
          rf_sp_wdata = wb_val_r;
          if (!ld_pending_r) begin
            rf_waddr = REG_SP;
          end
          state_nx = S_DONE;
        end else if (!ld_pending_r) begin
          rf_ld_rd = 1'b1;
          rf_waddr = base_idx_r;
          rf_wdata = wb_val_r;
          state_nx = S_DONE;
        end
      end
      S_FAULT: begin
`ifdef SEQ_ALIGN_CHECK_EN
        fault = 1'b1;
`endif
        state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_reglist_transfer_seq.sv
// Randomized bench for reglist_transfer_seq with a queue-based transfer model.
// Honours SEQ_ALIGN_CHECK_EN when it is defined for the build.
module tb_reglist_transfer_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [7:0]  reg_list;
  logic        extra;
  logic [2:0]  base_idx;
  logic [31:0] base_val;
  logic        busy, done;
  logic [3:0]  rf_raddr, rf_waddr;
  logic [31:0] rf_rdata, rf_wdata, rf_sp_wdata;
  logic        rf_ld_rd, rf_ld_pc, rf_ld_sp;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        fault;

  logic [31:0] rf_env [16];
  logic [31:0] mem_env [logic [31:0]];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  assign rf_rdata = rf_env[rf_raddr];

  reglist_transfer_seq #(.ADDR_W(32), .LIST_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .reg_list(reg_list), .extra(extra),
    .base_idx(base_idx), .base_val(base_val), .busy(busy), .done(done),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_ld_rd(rf_ld_rd), .rf_ld_pc(rf_ld_pc), .rf_ld_sp(rf_ld_sp), .rf_sp_wdata(rf_sp_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .fault(fault)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One complete operation: build the expected word sequence, act as bus and register file, compare.
  task automatic applyStimulus(input logic [1:0] op_i, input logic [7:0] list_i, input logic extra_i,
                               input logic [2:0] bi_i, input logic [31:0] base_i,
                               input int wait_fix, input int abort_at);
    int          regs[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_wd[$];
    logic [31:0] exp_rf[16];
    logic [31:0] base, span, a, sp_before;
    int          n, k, xfer_idx, req_cnt, wait_now, lat_acc, lat_exp;
    bit          is_store, misal, conf, in_req, done_seen, aborted;

    for (int i = 0; i < 8; i++) if (list_i[i]) regs.push_back(i);
    if (extra_i && op_i == 2'b10) regs.push_back(14);
    if (extra_i && op_i == 2'b11) regs.push_back(15);
    n        = regs.size();
    base     = base_i & 32'hFFFF_FFFC;
    span     = 32'(n) * 32'd4;
    is_store = (op_i == 2'b00) || (op_i == 2'b10);
    misal    = 1'b0;
`ifdef SEQ_ALIGN_CHECK_EN
    misal    = (base_i[1:0] != 2'b00);
`endif
    for (int i = 0; i < 16; i++) exp_rf[i] = rf_env[i];
    sp_before = rf_env[13];

    if (!misal) begin
      for (int j = 0; j < n; j++) begin
        a = ((op_i == 2'b10) ? base - span : base) + 32'(j) * 32'd4;
        exp_addr.push_back(a);
        if (is_store) begin
          exp_wd.push_back(rf_env[regs[j]]);
        end else begin
          if (!mem_env.exists(a)) mem_env[a] = $urandom;
          exp_rf[regs[j]] = (regs[j] == 15) ? (mem_env[a] & 32'hFFFF_FFFE) : mem_env[a];
        end
      end
      if (n > 0) begin
        case (op_i)
          2'b00: exp_rf[bi_i] = base + span;
          2'b01: if (!list_i[bi_i]) exp_rf[bi_i] = base + span;
          2'b10: exp_rf[13] = base - span;
          default: exp_rf[13] = base + span;
        endcase
      end
    end
    conf = !misal && (op_i == 2'b01) && (n > 0) && !list_i[bi_i];

    @(negedge clk);
    start = 1'b1; op = op_i; reg_list = list_i; extra = extra_i; base_idx = bi_i; base_val = base_i;
    @(negedge clk);
    start = 1'b0;
    k = 1; xfer_idx = 0; req_cnt = 0; wait_now = 0; lat_acc = 0;
    in_req = 1'b0; done_seen = 1'b0; aborted = 1'b0;

    while (!done_seen && k <= 400) begin
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (mem_req && !in_req) begin
        in_req   = 1'b1;
        req_cnt  = 0;
        wait_now = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 3));
        lat_acc += 2 + wait_now;
        if (abort_at > 0 && xfer_idx == abort_at - 1) begin
          rst = 1'b1;
          #1;
          checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
          checkOutput("rst_busy", 32'(busy), 32'd0);
          checkOutput("rst_ld_sp", 32'(rf_ld_sp), 32'd0);
          @(negedge clk);
          rst = 1'b0;
          checkOutput("rst_sp_kept", rf_env[13], sp_before);
          aborted = 1'b1;
          break;
        end
      end else if (!mem_req && in_req) begin
        checkOutput("req_held", 32'(mem_req), 32'd1);
        in_req = 1'b0;
      end
      if (mem_req) begin
        req_cnt++;
        if (xfer_idx < n) begin
          checkOutput("mem_addr", mem_addr, exp_addr[xfer_idx]);
          checkOutput("mem_we", 32'(mem_we), 32'(is_store));
        end else begin
          checkOutput("extra_req", 32'(mem_req), 32'd0);
        end
        if (req_cnt == wait_now + 1) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            if (xfer_idx < n) checkOutput("mem_wdata", mem_wdata, exp_wd[xfer_idx]);
            mem_env[mem_addr] = mem_wdata;
          end else if (mem_env.exists(mem_addr)) begin
            mem_rdata = mem_env[mem_addr];
          end
          in_req = 1'b0;
          xfer_idx++;
        end
      end
      if (rf_ld_rd) rf_env[rf_waddr] = rf_wdata;
      if (rf_ld_pc) rf_env[15] = rf_wdata;
      if (rf_ld_sp) rf_env[13] = rf_sp_wdata;
      checkOutput("fault", 32'(fault), 32'(misal && k == 1));
      checkOutput("busy", 32'(busy), 32'd1);
      if (done) begin
        lat_exp   = misal ? 2 : lat_acc + 2 + int'(conf);
        checkOutput("done_latency", 32'(k), 32'(lat_exp));
        done_seen = 1'b1;
        start     = 1'b0;
      end else begin
        // Traffic on the request inputs while busy must be ignored.
        start    = ($urandom_range(0, 3) == 0);
        op       = 2'($urandom);
        reg_list = 8'($urandom);
        extra    = 1'($urandom);
        base_idx = 3'($urandom);
        base_val = $urandom;
      end
      @(negedge clk);
      k++;
    end

    start = 1'b0;
    mem_ack = 1'b0;
    if (!aborted) begin
      checkOutput("done_seen", 32'(done_seen), 32'd1);
      checkOutput("done_pulse", 32'(done), 32'd0);
      checkOutput("busy_end", 32'(busy), 32'd0);
      checkOutput("xfer_count", 32'(xfer_idx), misal ? 32'd0 : 32'(n));
      for (int i = 0; i < 16; i++) checkOutput($sformatf("rf[%0d]", i), rf_env[i], exp_rf[i]);
    end
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [7:0]  r_list;
    logic [2:0]  r_bi;
    logic [31:0] r_base;

    rst = 1'b1; start = 1'b0; op = '0; reg_list = '0; extra = 1'b0; base_idx = '0;
    base_val = '0; mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) rf_env[i] = $urandom;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
    checkOutput("reset_strobes", 32'({rf_ld_rd, rf_ld_pc, rf_ld_sp}), 32'd0);
    rst = 1'b0;

    $display("[TB] PUSH {R1,R3,LR}");
    rf_env[13] = 32'h1000;
    applyStimulus(2'b10, 8'b0000_1010, 1'b1, 3'd0, 32'h1000, 0, 0);
    checkOutput("push_sp", rf_env[13], 32'h0FF4);
    checkOutput("push_lr_mem", mem_env[32'h0FFC], rf_env[14]);

    $display("[TB] POP {R0,PC}");
    rf_env[13] = 32'h0FF8;
    mem_env[32'h0FF8] = 32'h11;
    mem_env[32'h0FFC] = 32'h203;
    applyStimulus(2'b11, 8'b0000_0001, 1'b1, 3'd0, 32'h0FF8, 0, 0);
    checkOutput("pop_r0", rf_env[0], 32'h11);
    checkOutput("pop_pc", rf_env[15], 32'h202);
    checkOutput("pop_sp", rf_env[13], 32'h1000);

    $display("[TB] LDMIA R2!,{R1,R2}");
    rf_env[2] = 32'h2000;
    applyStimulus(2'b01, 8'b0000_0110, 1'b0, 3'd2, 32'h2000, 0, 0);

    $display("[TB] STMIA R0!,{R4} with slow ack");
    rf_env[0] = 32'h3000;
    applyStimulus(2'b00, 8'b0001_0000, 1'b0, 3'd0, 32'h3000, 3, 0);
    checkOutput("stm_r0", rf_env[0], 32'h3004);

    $display("[TB] empty list");
    applyStimulus(2'b00, 8'h00, 1'b0, 3'd3, rf_env[3], 1, 0);

    $display("[TB] reset during PUSH");
    rf_env[13] = 32'h1000;
    applyStimulus(2'b10, 8'b0000_0111, 1'b1, 3'd0, 32'h1000, 1, 2);
    applyStimulus(2'b10, 8'b0000_0111, 1'b1, 3'd0, 32'h1000, 0, 0);

    $display("[TB] misaligned PUSH");
    rf_env[13] = 32'h1002;
    applyStimulus(2'b10, 8'b0010_0000, 1'b1, 3'd0, 32'h1002, 0, 0);

    $display("[TB] random operations");
    repeat (40) begin
      r_op   = 2'($urandom);
      r_list = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      r_bi   = 3'($urandom);
      if (r_op[1]) begin
        r_base = 32'h8000 + (32'($urandom_range(0, 255)) << 2);
        rf_env[13] = r_base;
      end else begin
        r_base = 32'h1_0000 + (32'($urandom_range(0, 1023)) << 2);
        rf_env[r_bi] = r_base;
      end
      if ($urandom_range(0, 3) == 0) r_base = r_base | 32'($urandom_range(1, 3));
      applyStimulus(r_op, r_list, 1'($urandom), r_bi, r_base, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
